reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  32-entry general-purpose register file for the single-cycle datapath.
//  Two combinational read ports feed the ALU: rd2 is the register operand of
//  the ALU-source 2:1 mux, rd1 is the ALU A operand. One synchronous write
//  port takes the write-back result.
//  Register 0 reads as zero. A third read port serves debug/testbench visibility.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   address width; depth = 2**ADDR_W
//  BYPASS  0   1 = write-first forwarding on read ports; 0 = read-old-value
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous, active-high reset
//  ra1       in   ADDR_W  read address, port 1 (rs)
//  ra2       in   ADDR_W  read address, port 2 (rt)
//  rd1       out  DATA_W  read data, port 1
//  rd2       out  DATA_W  read data, port 2 (feeds ALU-source mux D2 input)
//  we        in   1       write enable
//  wa        in   ADDR_W  write address (rd)
//  wd        in   DATA_W  write data
//  dbg_addr  in   ADDR_W  debug read address
//  dbg_data  out  DATA_W  debug read data (never bypassed)
//  wr_count  out  32      count of committed writes since reset (wraps)
// BEHAVIOUR
//  - Reset: while rst=1, all 2**ADDR_W entries are 0 and wr_count = 0, so
//    rd1/rd2/dbg_data = 0. Applies asynchronously; release takes effect
//    at the next clk edge.
//  - Reset mid-write: rst beats we. An edge with rst=1 commits nothing.
//  - Reads: combinational, 0-cycle latency. rdN = regs[raN]. raN=0 always gives 0.
//  - Write: on posedge clk, if we=1 and wa!=0, regs[wa] <= wd and
//    wr_count <= wr_count+1 (mod 2**32).
//    A write with wa=0 is discarded and does not increment wr_count.
//    we=0 leaves all state unchanged.
//  - Read-during-write, same address, BYPASS=0: the read returns the pre-edge
//    value until the edge, then the new value. This is the mode the
//    single-cycle datapath uses: wd depends combinationally on rd1/rd2, and
//    bypassing would create a combinational loop.
//  - BYPASS=1: if we=1, wa!=0 and raN==wa, then rdN = wd in the same cycle.
//    Only for pipelined use. The dbg port never bypasses.
//  - ra1==ra2: both ports return the same value. No port priority exists.
//  - No X propagation from storage: every entry is defined after reset.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - DATA_W=32, ADDR_W=5
//    - REG_ZERO = 5'd0
//    - typedefs word_t [31:0] and reg_addr_t [4:0], shared with the ALU,
//      the mux and decode
//  - Single module with no sub-modules:
//    - storage array plus write logic in one always block, sensitive to
//      posedge clk / posedge rst
//    - read muxing as continuous assigns
//    - a generate branch on BYPASS selects the forwarding path
// TESTING
//  1. Assert rst mid-run after loading values.
//     -> all dbg_data reads 0 immediately, before any clk edge; wr_count = 0.
//  2. we=1, wa=5, wd=32'hDEADBEEF; next cycle ra1=5, ra2=5.
//     -> rd1 = rd2 = 32'hDEADBEEF; wr_count = 1.
//  3. we=1, wa=0, wd=32'hFFFFFFFF; then ra1=0.
//     -> rd1 = 0; wr_count unchanged.
//  4. BYPASS=0: reg7 = 32'h11. Drive we=1, wa=7, wd=32'h22, ra2=7.
//     -> rd2 = 32'h11 before the edge, 32'h22 after.
//     BYPASS=1, same stimulus -> rd2 = 32'h22 before the edge.
//  5. rst asserted in the same cycle as we=1, wa=3, wd=32'h55.
//     -> reg3 = 0 after the edge; wr_count = 0.
//  6. Write regs 1..31 with value = index*3, then sweep dbg_addr 0..31.
//     -> dbg_data = 0 for address 0, otherwise index*3; wr_count = 31.

Source files
------------

// File: rtl/cpu_pkg.sv
// Datapath-wide widths and types shared by the register file, ALU, operand mux and decode.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file.sv
// 2**ADDR_W-entry register file: two combinational read ports, one debug read port,
// one synchronous write port, register 0 hard-wired to zero, optional write-first bypass.
module reg_file #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [31:0]       wr_count_q, wr_count_d;
  logic              wr_en;
  logic [DATA_W-1:0] rd1_raw, rd2_raw;

  // Writes to register 0 are dropped entirely, including the commit count.
  assign wr_en      = we && (wa != '0);
  assign wr_count_d = wr_count_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else if (wr_en) begin
      regs_q[wa] <= wd;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd1_raw  = (ra1 == '0)      ? '0 : regs_q[ra1];
  assign rd2_raw  = (ra2 == '0)      ? '0 : regs_q[ra2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  assign wr_count = wr_count_q;

  // Forwarding must stay off in the single-cycle datapath: wd is a function of rd1/rd2.
  generate
    if (BYPASS) begin : g_byp
      assign rd1 = (wr_en && (ra1 == wa)) ? wd : rd1_raw;
      assign rd2 = (wr_en && (ra2 == wa)) ? wd : rd2_raw;
    end else begin : g_nobyp
      assign rd1 = rd1_raw;
      assign rd2 = rd2_raw;
    end
  endgenerate
endmodule

// File: tb/tb_reg_file.sv
// Directed stimulus for reg_file; expectations are queued and checked by a separate monitor.
module tb_reg_file;
  import cpu_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t ra1, ra2, wa, dbg_addr;
  logic      we;
  word_t     wd;
  word_t     rd1, rd2, dbg_data, rd1_b, rd2_b, dbg_data_b;
  logic [31:0] wr_count, wr_count_b;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b),
    .wr_count(wr_count_b)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RD1, K_RD2, K_DBG, K_WRC, K_RD1B, K_RD2B, K_DBGB} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   req_cnt = 0;
  int   ack_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic expect_val(input kind_e k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  // Hand the queued expectations to the monitor and wait (bounded) until it has consumed them.
  task automatic sample();
    int i;
    req_cnt++;
    for (i = 0; i < 100 && ack_cnt != req_cnt; i++) #1;
    if (ack_cnt != req_cnt) begin
      errors++;
      $display("FAIL monitor_timeout got ack %0d want %0d", ack_cnt, req_cnt);
      ack_cnt = req_cnt;
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      wait (req_cnt != ack_cnt);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          K_RD1:   act = rd1;
          K_RD2:   act = rd2;
          K_DBG:   act = dbg_data;
          K_WRC:   act = wr_count;
          K_RD1B:  act = rd1_b;
          K_RD2B:  act = rd2_b;
          default: act = dbg_data_b;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s got %h want %h", e.name, act, e.val);
        end
      end
      ack_cnt++;
    end
  end

  task automatic wr(input reg_addr_t a, input word_t d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1; we = 1'b0; wa = REG_ZERO; wd = '0;
    ra1 = REG_ZERO; ra2 = REG_ZERO; dbg_addr = 5'd9;
    #2;
    expect_val(K_RD1, 32'h0, "reset_rd1");
    expect_val(K_DBG, 32'h0, "reset_dbg");
    expect_val(K_WRC, 32'h0, "reset_wrcnt");
    sample();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic write, both ports on the same address
    wr(5'd5, 32'hDEADBEEF);
    ra1 = 5'd5; ra2 = 5'd5;
    expect_val(K_RD1,  32'hDEADBEEF, "wr5_rd1");
    expect_val(K_RD2,  32'hDEADBEEF, "wr5_rd2");
    expect_val(K_RD1B, 32'hDEADBEEF, "wr5_rd1_byp");
    expect_val(K_WRC,  32'd1,        "wr5_wrcnt");
    sample();

    // Write to r0 is discarded
    wr(REG_ZERO, 32'hFFFFFFFF);
    ra1 = REG_ZERO; dbg_addr = REG_ZERO;
    expect_val(K_RD1, 32'h0, "r0_rd1");
    expect_val(K_DBG, 32'h0, "r0_dbg");
    expect_val(K_WRC, 32'd1, "r0_wrcnt");
    sample();

    // Read-during-write on port 2, with and without forwarding
    wr(5'd7, 32'h11);
    we = 1'b1; wa = 5'd7; wd = 32'h22; ra2 = 5'd7; dbg_addr = 5'd7;
    expect_val(K_RD2,  32'h11, "rdw_rd2_pre");
    expect_val(K_RD2B, 32'h22, "rdw_rd2_byp_pre");
    expect_val(K_DBGB, 32'h11, "rdw_dbg_byp_pre");
    sample();
    @(posedge clk);
    expect_val(K_RD2, 32'h22, "rdw_rd2_post");
    expect_val(K_WRC, 32'd3,  "rdw_wrcnt");
    sample();
    @(negedge clk);
    we = 1'b0; wd = 32'hCAFEF00D;
    @(negedge clk);
    expect_val(K_WRC, 32'd3,  "we0_wrcnt");
    expect_val(K_RD2, 32'h22, "we0_rd2");
    sample();

    // Asynchronous reset mid-cycle clears everything immediately
    #2;
    rst = 1'b1; dbg_addr = 5'd5;
    #1;
    expect_val(K_DBG, 32'h0, "async_rst_dbg5");
    expect_val(K_RD2, 32'h0, "async_rst_rd2");
    expect_val(K_WRC, 32'h0, "async_rst_wrcnt");
    sample();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset wins over a simultaneous write
    wr(5'd3, 32'h99);
    rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h55;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; dbg_addr = 5'd3;
    #1;
    expect_val(K_DBG, 32'h0, "rst_vs_we_dbg3");
    expect_val(K_WRC, 32'h0, "rst_vs_we_wrcnt");
    sample();
    @(negedge clk);

    // Fill r1..r31 and sweep the debug port
    for (int i = 1; i < 32; i++) wr(reg_addr_t'(i), word_t'(i * 3));
    expect_val(K_WRC, 32'd31, "fill_wrcnt");
    sample();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = reg_addr_t'(i);
      expect_val(K_DBG, (i == 0) ? 32'h0 : 32'(i * 3), $sformatf("sweep_dbg%0d", i));
      sample();
    end
    ra1 = 5'd31; ra2 = 5'd16;
    expect_val(K_RD1, 32'd93, "sweep_rd1_r31");
    expect_val(K_RD2, 32'd48, "sweep_rd2_r16");
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
